// File: rtl/intra_pkg.sv
// rtl/intra_pkg.sv - shared types and helpers for the intra reconstruction pipe
package intra_pkg;

   typedef enum logic [1:0] {MODE_V, MODE_H, MODE_DC, MODE_RSVD} mode_e;
   typedef enum logic [1:0] {IDLE, PREP, ROWS} state_e;

   localparam int PIX_MID = 128;

   function automatic int clip_pix(input int v, input int pmax);
      if (v < 0) return 0;
      if (v > pmax) return pmax;
      return v;
   endfunction

endpackage

// File: rtl/intra_line_buf.sv
// rtl/intra_line_buf.sv - top-neighbour line buffer, one entry per block column
module intra_line_buf #(
   parameter int DEPTH = 80,
   parameter int WIDTH = 128,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/intra_recon_pipe.sv
// rtl/intra_recon_pipe.sv - V/H/DC intra prediction plus residue add, one row per beat
module intra_recon_pipe
   import intra_pkg::*;
#(
   parameter int BLK     = 16,
   parameter int PIX_W   = 8,
   parameter int RES_W   = 9,
   parameter int FRAME_W = 1280,
   parameter int FRAME_H = 720,
   localparam int XW     = $clog2(FRAME_W / BLK),
   localparam int YW     = $clog2(FRAME_H / BLK)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 blk_valid,
   output logic                 blk_ready,
   input  logic [1:0]           blk_mode,
   input  logic [XW-1:0]        blk_x,
   input  logic [YW-1:0]        blk_y,
   input  logic                 res_valid,
   output logic                 res_ready,
   input  logic [BLK*RES_W-1:0] res_row,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BLK*PIX_W-1:0] out_row,
   output logic                 out_last
);

   localparam int RW    = $clog2(BLK);
   localparam int ACC_W = PIX_W + RW + 1;
   localparam int ROW_W = BLK * PIX_W;
   localparam logic [PIX_W-1:0] MID = PIX_W'(PIX_MID);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic [ROW_W-1:0] top_q, top_d;
   logic [ROW_W-1:0] left_q, left_d;
   logic [PIX_W-1:0] dc_q, dc_d;
   logic [RW-1:0]    row_q, row_d;
   logic             done_q, done_d;
   logic             blk_ready_q, blk_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [ROW_W-1:0] out_row_q, out_row_d;

   logic [ROW_W-1:0] buf_rd_data;
   logic [ROW_W-1:0] rec_row;
   logic [PIX_W-1:0] dc_calc;
   logic             top_av, left_av, hdr_fire, res_fire, last_row, buf_wr_en;

   assign top_av    = (y_q != '0);
   assign left_av   = (x_q != '0);
   assign hdr_fire  = blk_valid && blk_ready_q;
   // done_q keeps the engine from taking a row of the next block before the header.
   assign res_ready = (state_q == ROWS) && !done_q && (!out_valid_q || out_ready);
   assign res_fire  = res_valid && res_ready && !reset;
   assign last_row  = (row_q == RW'(BLK - 1));
   assign buf_wr_en = res_fire && last_row;

   intra_line_buf #(
      .DEPTH (FRAME_W / BLK),
      .WIDTH (ROW_W),
      .AW    (XW)
   ) u_top_buf (
      .clk     (clk),
      .rd_addr (blk_x),
      .rd_data (buf_rd_data),
      .wr_en   (buf_wr_en),
      .wr_addr (x_q),
      .wr_data (rec_row)
   );

   always_comb begin : dc_sum
      logic [ACC_W-1:0] sum_t, sum_l, acc;
      sum_t = '0;
      sum_l = '0;
      for (int k = 0; k < BLK; k++) begin
         sum_t += ACC_W'(buf_rd_data[k*PIX_W +: PIX_W]);
         sum_l += ACC_W'(left_q[k*PIX_W +: PIX_W]);
      end
      if (top_av && left_av)  acc = (sum_t + sum_l + ACC_W'(BLK)) >> (RW + 1);
      else if (top_av)        acc = (sum_t + ACC_W'(BLK / 2)) >> RW;
      else if (left_av)       acc = (sum_l + ACC_W'(BLK / 2)) >> RW;
      else                    acc = ACC_W'(PIX_MID);
      dc_calc = acc[PIX_W-1:0];
   end

   always_comb begin : recon
      logic [PIX_W-1:0]      pred;
      logic signed [RES_W:0] p_ext, r_ext, s;
      rec_row = '0;
      for (int k = 0; k < BLK; k++) begin
         case (mode_q)
            MODE_V:  pred = top_q[k*PIX_W +: PIX_W];
            MODE_H:  pred = left_av ? left_q[row_q*PIX_W +: PIX_W] : MID;
            default: pred = dc_q;
         endcase
         p_ext = {{(RES_W + 1 - PIX_W){1'b0}}, pred};
         r_ext = {res_row[k*RES_W + RES_W - 1], res_row[k*RES_W +: RES_W]};
         s     = p_ext + r_ext;
         rec_row[k*PIX_W +: PIX_W] = PIX_W'(clip_pix(int'(s), (1 << PIX_W) - 1));
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      x_d         = x_q;
      y_d         = y_q;
      top_d       = top_q;
      dc_d        = dc_q;
      left_d      = left_q;
      row_d       = row_q;
      done_d      = done_q;
      out_valid_d = out_valid_q;
      out_row_d   = out_row_q;
      out_last_d  = out_last_q;
      case (state_q)
         IDLE: begin
            if (hdr_fire) begin
               state_d = PREP;
               mode_d  = mode_e'(blk_mode);
               x_d     = blk_x;
               y_d     = blk_y;
               row_d   = '0;
               done_d  = 1'b0;
            end
         end
         PREP: begin
            state_d = ROWS;
            for (int k = 0; k < BLK; k++)
               top_d[k*PIX_W +: PIX_W] = top_av ? buf_rd_data[k*PIX_W +: PIX_W] : MID;
            dc_d = dc_calc;
         end
         ROWS: begin
            if (out_valid_q && out_last_q && out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (res_fire) begin
         row_d       = row_q + RW'(1);
         done_d      = last_row;
         left_d[row_q*PIX_W +: PIX_W] = rec_row[ROW_W-1 -: PIX_W];
         out_valid_d = 1'b1;
         out_row_d   = rec_row;
         out_last_d  = last_row;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      blk_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         row_q       <= '0;
         done_q      <= 1'b0;
         blk_ready_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         done_q      <= done_d;
         blk_ready_q <= blk_ready_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         out_last_q  <= out_last_d;
      end
   end

   // Neighbour and header state survive reset; a new header reloads what matters.
   always_ff @(posedge clk) begin
      mode_q <= mode_d;
      x_q    <= x_d;
      y_q    <= y_d;
      top_q  <= top_d;
      dc_q   <= dc_d;
      left_q <= left_d;
   end

   assign blk_ready = blk_ready_q;
   assign out_valid = out_valid_q;
   assign out_row   = out_row_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_intra_recon_pipe.sv
// tb/tb_intra_recon_pipe.sv - scoreboard bench for intra_recon_pipe
`timescale 1ns/1ps
module tb_intra_recon_pipe;

   localparam int BLK     = 4;
   localparam int PIX_W   = 8;
   localparam int RES_W   = 9;
   localparam int FRAME_W = 16;
   localparam int FRAME_H = 16;
   localparam int XW      = 2;
   localparam int YW      = 2;
   localparam int NCOL    = FRAME_W / BLK;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 blk_valid;
   logic                 blk_ready;
   logic [1:0]           blk_mode;
   logic [XW-1:0]        blk_x;
   logic [YW-1:0]        blk_y;
   logic                 res_valid;
   logic                 res_ready;
   logic [BLK*RES_W-1:0] res_row;
   logic                 out_valid;
   logic                 out_ready;
   logic [BLK*PIX_W-1:0] out_row;
   logic                 out_last;

   intra_recon_pipe #(
      .BLK(BLK), .PIX_W(PIX_W), .RES_W(RES_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H)
   ) dut (
      .clk(clk), .reset(reset),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_mode(blk_mode),
      .blk_x(blk_x), .blk_y(blk_y),
      .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BLK*PIX_W-1:0] row;
      logic                 last;
   } exp_t;

   exp_t exp_q[$];
   int total = 0, bad = 0, n_push = 0, n_pop = 0, cyc = 0;
   int top_m[NCOL][BLK];
   int left_m[BLK];
   int res_m[BLK][BLK];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic int clampi(input int v);
      return (v < 0) ? 0 : (v > 255) ? 255 : v;
   endfunction

   function automatic logic [BLK*RES_W-1:0] pack_row(input int r);
      logic [BLK*RES_W-1:0] p;
      for (int k = 0; k < BLK; k++) p[k*RES_W +: RES_W] = RES_W'(res_m[r][k]);
      return p;
   endfunction

   task automatic fill_res(input int v);
      for (int r = 0; r < BLK; r++)
         for (int k = 0; k < BLK; k++) res_m[r][k] = v;
   endtask

   task automatic fill_rand();
      for (int r = 0; r < BLK; r++)
         for (int k = 0; k < BLK; k++) res_m[r][k] = int'($urandom_range(0, 511)) - 256;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_extra_row", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            n_pop++;
            check_eq("row", out_row, e.row);
            check_eq("last", out_last, e.last);
         end
      end
   end

   task automatic run_block(input int bx, input int by, input int mode, input int nrows, input bit lat);
      int topv[BLK];
      int leftv[BLK];
      int st, sl, dc, n, c0, pred, v;
      bit ta, la;
      exp_t e;
      ta = (by != 0);
      la = (bx != 0);
      st = 0;
      sl = 0;
      for (int k = 0; k < BLK; k++) begin
         topv[k]  = ta ? top_m[bx][k] : 128;
         leftv[k] = la ? left_m[k] : 128;
         st += topv[k];
         sl += leftv[k];
      end
      if (ta && la)  dc = (st + sl + BLK) >> $clog2(2 * BLK);
      else if (ta)   dc = (st + BLK / 2) >> $clog2(BLK);
      else if (la)   dc = (sl + BLK / 2) >> $clog2(BLK);
      else           dc = 128;

      blk_valid = 1'b1;
      blk_mode  = 2'(mode);
      blk_x     = XW'(bx);
      blk_y     = YW'(by);
      res_row   = pack_row(0);
      res_valid = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (blk_ready) break;
      end
      if (n == 50) begin
         check_eq("hdr_timeout", n, 0);
         blk_valid = 1'b0;
         res_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
      c0 = cyc;
      for (int r = 0; r < nrows; r++) begin
         res_row   = pack_row(r);
         res_valid = 1'b1;
         for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (res_ready) break;
         end
         if (n == 50) begin
            check_eq("res_timeout", n, 0);
            res_valid = 1'b0;
            return;
         end
         e.row = '0;
         for (int k = 0; k < BLK; k++) begin
            pred = (mode == 0) ? topv[k] : (mode == 1) ? leftv[r] : dc;
            v = clampi(pred + res_m[r][k]);
            e.row[k*PIX_W +: PIX_W] = PIX_W'(v);
            if (k == BLK - 1) left_m[r] = v;
            if (r == BLK - 1) top_m[bx][k] = v;
         end
         e.last = (r == BLK - 1);
         exp_q.push_back(e);
         n_push++;
         @(posedge clk);
         #1;
         if (lat && r == 0) begin
            check_eq("lat_cycles", cyc - c0, 2);
            check_eq("lat_valid", out_valid, 1);
         end
      end
      res_valid = 1'b0;
   endtask

   task automatic backpressure();
      int n;
      for (n = 0; n < 50; n++) begin
         @(posedge clk);
         #1;
         if (out_valid) break;
      end
      check_eq("bp_start", n < 50, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_eq("bp_res_ready", res_ready, 0);
         check_eq("bp_valid", out_valid, 1);
         check_eq("bp_hold", out_row, exp_q[0].row);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      blk_valid = 1'b0;
      blk_mode  = '0;
      blk_x     = '0;
      blk_y     = '0;
      res_valid = 1'b0;
      res_row   = '0;
      out_ready = 1'b1;
      for (int c = 0; c < NCOL; c++)
         for (int k = 0; k < BLK; k++) top_m[c][k] = 0;
      for (int k = 0; k < BLK; k++) left_m[k] = 0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("rst_blk_ready", blk_ready, 0);
      check_eq("rst_res_ready", res_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_row", out_row, 0);
      check_eq("rst_out_last", out_last, 0);
      @(posedge clk);
      #1;
      check_eq("rst_blk_ready_up", blk_ready, 1);

      fill_res(0);
      run_block(0, 0, 2, BLK, 1);

      for (int r = 0; r < BLK; r++)
         for (int k = 0; k < BLK; k++) res_m[r][k] = r + 1 - 128;
      run_block(0, 0, 2, BLK, 0);
      fill_res(0);
      run_block(1, 0, 1, BLK, 0);

      fill_res(0);
      for (int k = 0; k < BLK; k++) res_m[BLK-1][k] = 10 * (k + 1) - 128;
      run_block(0, 0, 2, BLK, 0);
      fill_res(5);
      fork
         run_block(0, 1, 0, BLK, 0);
         backpressure();
      join

      fill_rand();
      for (int k = 0; k < BLK; k++) res_m[BLK-1][k] = (k % 2 == 0) ? 122 : -125;
      run_block(2, 0, 0, BLK, 0);
      for (int r = 0; r < BLK; r++)
         for (int k = 0; k < BLK; k++) res_m[r][k] = (k % 2 == 0) ? 20 : -10;
      run_block(2, 1, 0, BLK, 0);

      fill_rand();
      run_block(1, 1, 2, BLK, 0);

      fill_rand();
      run_block(3, 0, 2, 2, 0);
      reset     = 1'b1;
      res_valid = 1'b1;
      res_row   = pack_row(2);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      res_valid = 1'b0;
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_out_last", out_last, 0);
      check_eq("mid_rst_res_ready", res_ready, 0);
      check_eq("mid_rst_blk_ready", blk_ready, 0);
      @(posedge clk);
      #1;
      check_eq("mid_rst_idle", blk_ready, 1);

      fill_rand();
      run_block(0, 0, 3, BLK, 0);

      for (n = 0; n < 50; n++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check_eq("sb_drain", exp_q.size(), 0);
      check_eq("rows_out", n_pop, n_push);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
